// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: funct3 load/store lengths,
// FSM state codes and the default IO address window selector.
package mem_ctrl_pkg;

  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

  localparam logic [1:0] IO_ADDR_BITS_DEF = 2'b11;

  // Byte count of an access; the reserved size code 3 is treated as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Combinational sign/zero extender for byte, half and word load results.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  len,
  output logic [31:0] ext
);

  logic sgn_b;
  logic sgn_h;

  assign sgn_b = raw[7] & ~len[2];
  assign sgn_h = raw[15] & ~len[2];

  always_comb begin
    case (len[1:0])
      2'd0:    ext = {{24{sgn_b}}, raw[7:0]};
      2'd1:    ext = {{16{sgn_h}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSB port (priority) and instruction-fetch port
// onto a single-port synchronous RAM/IO bus. Define MEM_CTRL_IO_STALL_EN to hold
// IO-mapped stores while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 32,
  parameter logic [1:0] IO_ADDR_BITS = IO_ADDR_BITS_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear,
  input  logic                  mem_valid,
  input  logic                  mem_wr,
  input  logic [2:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_value,
  output logic                  mem_ready,
  output logic [31:0]           mem_result,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_buffer_full
);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [23:0] byte_buf;
  logic        wr_q;
  logic [31:0] wdata;
  logic [2:0]  req_len;
  logic [2:0]  n;
  logic [31:0] raw;
  logic [31:0] ext;
  logic        io_block;
  logic        take_mem;
  logic        take_if;

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_block = mem_valid && mem_wr && (mem_addr[17:16] == IO_ADDR_BITS) && io_buffer_full;
`else
  logic unused_io;
  assign io_block  = 1'b0;
  assign unused_io = io_buffer_full & (mem_addr[17:16] == IO_ADDR_BITS);
`endif

  // A blocked or flushed LSB request still owns the bus, so fetch waits behind it.
  assign take_mem = mem_valid && !io_block && (mem_wr || !rob_clear);
  assign take_if  = !mem_valid && if_valid && !rob_clear;

  assign n = (state == ST_FETCH) ? 3'd4 : len_bytes(req_len[1:0]);

  // The last byte is taken straight off ram_din during the ready cycle.
  always_comb begin
    raw = {ram_din, byte_buf};
    case (n)
      3'd1:    raw = {24'd0, ram_din};
      3'd2:    raw = {16'd0, ram_din, byte_buf[7:0]};
      default: raw = {ram_din, byte_buf};
    endcase
  end

  mem_ext u_ext (
    .raw (raw),
    .len (req_len),
    .ext (ext)
  );

  assign mem_ready  = rdy_in && (((state == ST_LOAD) && (cnt == n) && !rob_clear) ||
                                 ((state == ST_STORE) && (cnt == n - 3'd1)));
  assign if_ready   = rdy_in && (state == ST_FETCH) && (cnt == 3'd4) && !rob_clear;
  assign mem_result = (mem_ready && (state == ST_LOAD)) ? ext : 32'd0;
  assign if_data    = if_ready ? raw : 32'd0;
  assign ram_wr     = wr_q && rdy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      byte_buf <= 24'd0;
      wr_q     <= 1'b0;
      ram_a    <= '0;
      ram_dout <= 8'd0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          cnt <= 3'd0;
          if (take_mem) begin
            state    <= mem_wr ? ST_STORE : ST_LOAD;
            ram_a    <= mem_addr;
            wr_q     <= mem_wr;
            ram_dout <= mem_value[7:0];
          end else if (take_if) begin
            state <= ST_FETCH;
            ram_a <= if_addr;
            wr_q  <= 1'b0;
          end
        end
        ST_STORE: begin
          if (cnt + 3'd1 < n) begin
            cnt      <= cnt + 3'd1;
            ram_a    <= ram_a + ADDR_WIDTH'(1);
            ram_dout <= wdata[15:8];
          end else begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            wr_q  <= 1'b0;
          end
        end
        default: begin
          if (rob_clear || (cnt == n)) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            wr_q  <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 < n) ram_a <= ram_a + ADDR_WIDTH'(1);
            case (cnt)
              3'd1:    byte_buf[7:0]   <= ram_din;
              3'd2:    byte_buf[15:8]  <= ram_din;
              3'd3:    byte_buf[23:16] <= ram_din;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Request payload registers carry no reset; they are only read after an accept.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if ((state == ST_IDLE) && take_mem) begin
        wdata   <= mem_value;
        req_len <= mem_len;
      end else if (state == ST_STORE) begin
        wdata <= {8'd0, wdata[31:8]};
      end
    end
  end

endmodule
